sm2_fast_reduce: RTL and testbench

- Consumer end of the 256x256 multiplier datapath: accepts the 512-bit product and returns it reduced modulo the SM2 prime p = 2^256 - 2^224 - 2^96 + 2^64 - 1.
- Uses iterative shift/add folding with the identity 2^256 ≡ c (mod p), where c = 2^224 + 2^96 - 2^64 + 1. No multipliers.
- Ends with one conditional subtraction of p.
- Valid/ready on both sides so it can sit directly behind the registered multiplier wrapper and ahead of the Montgomery/point-arithmetic sequencer.

---
 rtl/sm2_fast_reduce.sv | 141 ++++++++++++++
 tb/tb_sm2_fast_reduce.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm2_fast_reduce.sv
`default_nettype none
// ============================================================================
// Module   : sm2_fast_reduce
// Purpose  : Reduces a 512-bit product modulo the SM2 prime by iterative
//            shift/add folding (2^256 == c mod p) and one conditional
//            subtraction. Valid/ready on both sides.
// Options  : SM2_RED_FIXED_LATENCY_EN - constant MAX_FOLD+2 edge latency.
// Revision : 1.0 - initial release
// ============================================================================
module sm2_fast_reduce #(
    parameter int WIDTH    = 256,   // fold constants are SM2-specific: 256 only
    parameter int MAX_FOLD = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FOLD = 2'd1;
    localparam logic [1:0] c_SUB  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int                 c_CNT_W   = $clog2(MAX_FOLD + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_FOLD);
    localparam logic [WIDTH-1:0]   c_P       =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [2*WIDTH-1:0]   r_x;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_res;

    logic [WIDTH-1:0]     w_hi;
    logic [WIDTH-1:0]     w_lo;
    logic [2*WIDTH+1:0]   w_hi_ext;
    logic [2*WIDTH+1:0]   w_fold;
    logic                 w_hi_zero;
    logic                 w_fold_exit;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_sub_res;
    logic                 w_accept;

    assign w_hi      = r_x[2*WIDTH-1:WIDTH];
    assign w_lo      = r_x[WIDTH-1:0];
    assign w_hi_zero = (w_hi == '0);
    assign w_hi_ext  = {{(WIDTH+2){1'b0}}, w_hi};

    // hi*2^256 == hi*(2^224 + 2^96 - 2^64 + 1); the 514-bit sum may wrap
    // transiently but the final value is non-negative and below 2^482.
    assign w_fold = {{(WIDTH+2){1'b0}}, w_lo} + (w_hi_ext << 224) + (w_hi_ext << 96)
                  + w_hi_ext - (w_hi_ext << 64);

`ifdef SM2_RED_FIXED_LATENCY_EN
    assign w_fold_exit = (r_cnt == c_CNT_MAX);
`else
    assign w_fold_exit = w_hi_zero || (r_cnt == c_CNT_MAX);
`endif

    // x < 2^256 < 2p here, so a single subtraction is enough
    assign w_diff    = {1'b0, w_lo} - {1'b0, c_P};
    assign w_sub_res = w_diff[WIDTH] ? w_lo : w_diff[WIDTH-1:0];

    assign w_accept  = in_valid && (r_state == c_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)    w_state_nxt = c_FOLD;
            c_FOLD:  if (w_fold_exit) w_state_nxt = c_SUB;
            c_SUB:                    w_state_nxt = c_DONE;
            c_DONE:  if (out_ready)   w_state_nxt = c_IDLE;
            default:                  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        busy      = (r_state != c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_cnt <= '0;
            r_res <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_x   <= prod;
                        r_cnt <= '0;
                    end
                end
                c_FOLD: begin
                    // in the fixed-latency build, x stays put once hi is zero
                    if (!w_fold_exit) begin
                        if (!w_hi_zero) begin
                            r_x <= w_fold[2*WIDTH-1:0];
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_SUB: begin
                    r_res <= w_sub_res;
                end
                default: begin
                    r_res <= r_res;
                end
            endcase
        end
    end

    assign res = r_res;

`ifdef SM2_RED_FIXED_LATENCY_EN
    a_fold_done: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == c_FOLD && w_fold_exit) |-> w_hi_zero);
`else
    a_fold_cap: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_state == c_FOLD && !w_hi_zero && r_cnt == c_CNT_MAX));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm2_fast_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm2_fast_reduce
// Purpose  : Scoreboard bench for sm2_fast_reduce (directed + random vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm2_fast_reduce;

    localparam logic [255:0] c_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] c_C =
        256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;
`ifdef SM2_RED_FIXED_LATENCY_EN
    localparam int c_LAT_MIN = 14;
    localparam int c_LAT_MAX = 14;
`else
    localparam int c_LAT_MIN = 2;
    localparam int c_LAT_MAX = 13;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] prod = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] res;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    sm2_fast_reduce #(.WIDTH(256), .MAX_FOLD(12)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod      (prod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] exp;
        int           acc;
        int           lat;
        int           id;
    } txn_t;

    txn_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   rand_ready_en = 1'b0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int lat_of(input int folds);
`ifdef SM2_RED_FIXED_LATENCY_EN
        return 14 + 0 * folds;
`else
        return folds + 2;
`endif
    endfunction

    // Bit-serial long division: independent of the folding identity.
    function automatic logic [255:0] ref_mod(input logic [511:0] a);
        logic [256:0] r;
        r = '0;
        for (int i = 511; i >= 0; i--) begin
            r = {r[255:0], a[i]};
            if (r >= {1'b0, c_P}) r = r - {1'b0, c_P};
        end
        return r[255:0];
    endfunction

    // Monitor: runs on the falling edge, independent of the stimulus.
    bit           seen = 1'b0;
    logic [255:0] held;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 256'(out_valid), 256'(0));
            end else begin
                if (!seen) begin
                    int lat;
                    seen = 1'b1;
                    held = res;
                    lat  = cyc - sb[0].acc;
                    if (sb[0].lat >= 0) begin
                        check($sformatf("latency[%0d]", sb[0].id), 256'(lat), 256'(sb[0].lat));
                    end else begin
                        n_total++;
                        if (lat >= c_LAT_MIN && lat <= c_LAT_MAX) n_pass++;
                        else $display("FAIL latency_range[%0d]: got %0d expected %0d..%0d",
                                      sb[0].id, lat, c_LAT_MIN, c_LAT_MAX);
                    end
                end else begin
                    check($sformatf("res_stable[%0d]", sb[0].id), res, held);
                end
                check("in_ready_low_in_done", 256'(in_ready), 256'(0));
                if (out_ready) begin
                    check($sformatf("res[%0d]", sb[0].id), res, sb[0].exp);
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [511:0] v, input logic [255:0] e, input int lat, input int id);
        int   w;
        txn_t t;
        w = 0;
        prod = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check($sformatf("accept_timeout[%0d]", id), 256'(in_ready), 256'(1));
            in_valid = 1'b0;
            return;
        end
        t.exp = e; t.acc = cyc + 1; t.lat = lat; t.id = id;
        sb.push_back(t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 256'(sb.size()), 256'(0));
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] pm1;
        logic [511:0] v;
        int           w;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  256'(in_ready),  256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_res",       res,             256'(0));
        check("rst_busy",      256'(busy),      256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Directed vectors with hand-derived results and fold counts
        pm1 = {256'b0, c_P - 256'd1};
        send(512'd5,                       256'd5,          lat_of(0), 1);
        send(512'd1 << 256,                c_C,             lat_of(1), 2);
        send({256'b0, c_P},                256'd0,          lat_of(0), 3);
        send({256'b0, c_P - 256'd1},       c_P - 256'd1,    lat_of(0), 4);
        send({256'b0, {256{1'b1}}},        c_C - 256'd1,    lat_of(0), 5);
        send({256'b0, c_P} << 1,           256'd0,          lat_of(1), 6);
        send({256'b0, c_P} + 512'd5,       256'd5,          lat_of(0), 7);
        send(pm1 * pm1,                    256'd1,          -1,        8);
        send({512{1'b1}},                  ref_mod({512{1'b1}}), -1,   9);
        drain();

        // Reset while folding the all-ones product
        prod = {512{1'b1}};
        in_valid = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin w++; @(negedge clk); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("busy_mid_fold", 256'(busy), 256'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready",  256'(in_ready),  256'(1));
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_res",       res,             256'(0));
        check("midrst_busy",      256'(busy),      256'(0));
        @(posedge clk);
        #1;
        send(512'd5, 256'd5, lat_of(0), 10);
        drain();

        // Backpressure: second product waits behind a stalled result
        out_ready = 1'b0;
        send(512'd1 << 256, c_C, lat_of(1), 11);
        fork
            send({256'b0, c_P} + 512'd9, 256'd9, lat_of(0), 12);
            begin
                w = 0;
                while (!out_valid && w < 50) begin w++; @(negedge clk); end
                check("bp_out_valid_seen", 256'(out_valid), 256'(1));
                repeat (20) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 256'(in_ready), 256'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random sweep with random output backpressure
        rand_ready_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
            case (n % 4)
                1: v[511:256] = '0;
                2: v[511:288] = '0;
                3: v = {256'b0, c_P} + 512'($urandom_range(0, 3)) - 512'($urandom_range(0, 3));
                default: ;
            endcase
            send(v, ref_mod(v), -1, 100 + n);
        end
        drain();
        rand_ready_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
